// File: rtl/uart_cmd_rx.sv
// Purpose: 8N1 UART receiver feeding a 5-byte command parser (A5, addr, dhi, dlo, sum) that issues register writes.
// Latency: reg_wr_en/cmd_err 2 cycles and frame_err 1 cycle after the stop-bit sample edge.
// Backpressure: none; receive-only, and every validated command produces its strobe unconditionally.
//
// Ports:
//   clk_50M   - system clock, rising edge
//   rst_n     - asynchronous active-low reset
//   uart_rx   - asynchronous serial input, idle high
//   reg_wr_en - one-cycle write strobe; reg_addr/reg_wdata hold the last written command
//   frame_err - one-cycle pulse on a low stop bit
//   cmd_err   - one-cycle pulse on a checksum mismatch
//   rx_busy   - bit receiver is not idle
module uart_cmd_rx #(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD         = 115200,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic        clk_50M,
    input  logic        rst_n,
    input  logic        uart_rx,
    output logic        reg_wr_en,
    output logic [7:0]  reg_addr,
    output logic [15:0] reg_wdata,
    output logic        frame_err,
    output logic        cmd_err,
    output logic        rx_busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam int TW           = $clog2(TIMEOUT_BITS * CLKS_PER_BIT + 1);

    localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_BITS * CLKS_PER_BIT);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;

    localparam logic [2:0] P_HDR  = 3'd0;
    localparam logic [2:0] P_ADDR = 3'd1;
    localparam logic [2:0] P_DHI  = 3'd2;
    localparam logic [2:0] P_DLO  = 3'd3;
    localparam logic [2:0] P_SUM  = 3'd4;

    // Synchronizer plus one history flop for start-edge detection.
    logic          sync1_q, sync2_q, rx_prev_q;

    logic [2:0]    rx_state_q, rx_state_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          byte_vld_q, byte_vld_d;
    logic          frame_err_q, frame_err_d;

    logic [2:0]    p_state_q, p_state_d;
    logic [7:0]    addr_q, addr_d, dhi_q, dhi_d, dlo_q, dlo_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [7:0]    reg_addr_q, reg_addr_d;
    logic [15:0]   reg_wdata_q, reg_wdata_d;
    logic          wr_en_q, wr_en_d;
    logic          cmd_err_q, cmd_err_d;
    logic [7:0]    pkt_sum;

    // Bit receiver: the counter restarts at every sample so DATA/STOP samples land mid-bit.
    always_comb begin
        rx_state_d  = rx_state_q;
        bit_cnt_d   = bit_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        byte_vld_d  = 1'b0;
        frame_err_d = 1'b0;
        case (rx_state_q)
            S_IDLE: begin
                bit_cnt_d = '0;
                if (rx_prev_q && !sync2_q) rx_state_d = S_START;
            end
            S_START: begin
                if (bit_cnt_q == HALF_CNT) begin
                    bit_cnt_d  = '0;
                    bit_idx_d  = '0;
                    rx_state_d = sync2_q ? S_IDLE : S_DATA;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_cnt_q == FULL_CNT) begin
                    bit_cnt_d = '0;
                    shift_d   = {sync2_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) rx_state_d = S_STOP;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (bit_cnt_q == FULL_CNT) begin
                    bit_cnt_d = '0;
                    if (sync2_q) begin
                        byte_vld_d = 1'b1;
                        rx_state_d = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        rx_state_d  = S_WAIT;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (sync2_q) rx_state_d = S_IDLE;
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    assign pkt_sum = addr_q + dhi_q + dlo_q;

    // Packet parser. shift_q still holds the completed byte while byte_vld_q is high,
    // since the next byte cannot start shifting until at least half a bit later.
    always_comb begin
        p_state_d   = p_state_q;
        addr_d      = addr_q;
        dhi_d       = dhi_q;
        dlo_d       = dlo_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        wr_en_d     = 1'b0;
        cmd_err_d   = 1'b0;

        if (p_state_q == P_HDR || byte_vld_q) to_cnt_d = '0;
        else                                  to_cnt_d = to_cnt_q + 1'b1;

        if (byte_vld_q) begin
            case (p_state_q)
                P_HDR:  if (shift_q == 8'hA5) p_state_d = P_ADDR;
                P_ADDR: begin addr_d = shift_q; p_state_d = P_DHI; end
                P_DHI:  begin dhi_d  = shift_q; p_state_d = P_DLO; end
                P_DLO:  begin dlo_d  = shift_q; p_state_d = P_SUM; end
                P_SUM: begin
                    if (shift_q == pkt_sum) begin
                        reg_addr_d  = addr_q;
                        reg_wdata_d = {dhi_q, dlo_q};
                        wr_en_d     = 1'b1;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                    p_state_d = P_HDR;
                end
                default: p_state_d = P_HDR;
            endcase
        end else if (p_state_q != P_HDR && (frame_err_q || to_cnt_q == TO_LIMIT)) begin
            // Broken frame or stalled packet: abandon silently.
            p_state_d = P_HDR;
        end
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_state_q  <= S_IDLE;
            bit_cnt_q   <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            byte_vld_q  <= 1'b0;
            frame_err_q <= 1'b0;
            p_state_q   <= P_HDR;
            addr_q      <= '0;
            dhi_q       <= '0;
            dlo_q       <= '0;
            to_cnt_q    <= '0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            wr_en_q     <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            sync1_q     <= uart_rx;
            sync2_q     <= sync1_q;
            rx_prev_q   <= sync2_q;
            rx_state_q  <= rx_state_d;
            bit_cnt_q   <= bit_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            byte_vld_q  <= byte_vld_d;
            frame_err_q <= frame_err_d;
            p_state_q   <= p_state_d;
            addr_q      <= addr_d;
            dhi_q       <= dhi_d;
            dlo_q       <= dlo_d;
            to_cnt_q    <= to_cnt_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            wr_en_q     <= wr_en_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    assign reg_wr_en = wr_en_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign frame_err = frame_err_q;
    assign cmd_err   = cmd_err_q;
    assign rx_busy   = (rx_state_q != S_IDLE);

endmodule
